// File: rtl/sa_pkg.sv
// -----------------------------------------------------------------------------
// sa_pkg
// Types and constants shared by the systolic-array feeder, its skew pipe and
// the PE array.
//   SA_PE_DIM_DEFAULT : default array dimension (rows / skew stages)
//   sa_state_e        : feeder scheduler states
//   sa_sel_width()    : row-select width, never narrower than one bit
// -----------------------------------------------------------------------------
package sa_pkg;

  localparam int SA_PE_DIM_DEFAULT = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } sa_state_e;

  // A 1-row array still needs a 1-bit select port.
  function automatic int sa_sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sa_skew_pipe.sv
// -----------------------------------------------------------------------------
// sa_skew_pipe
// 1-bit delay line producing the skewed per-row valids of the PE array.
// dout[0] is din delayed one cycle; dout[i] is dout[0] delayed i more cycles.
// A synchronous clear empties every stage so a cancelled job leaves no
// stray row pulses behind.
// Ports:
//   clk    : clock
//   rstb   : asynchronous active-low reset
//   clear  : synchronous flush of all stages
//   din    : valid entering the line
//   dout   : [DEPTH-1:0] staged valids, bit i = row i
// -----------------------------------------------------------------------------
module sa_skew_pipe #(
  parameter int DEPTH = 3
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             clear,
  input  logic             din,
  output logic [DEPTH-1:0] dout
);

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      dout <= '0;
    end else if (clear) begin
      dout <= '0;
    end else begin
      dout[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        dout[i] <= dout[i-1];
      end
    end
  end

endmodule

// File: rtl/sa_feed_sched.sv
// -----------------------------------------------------------------------------
// sa_feed_sched
// Feed scheduler for a PE_DIM x PE_DIM systolic array. A job streams seq_len
// lines starting at base_addr out of the input memory (1-cycle read latency),
// writes line k into row buffer k mod PE_DIM, and generates the skewed
// per-row valids that walk data diagonally into the array. After the last
// read it waits PE_DIM+1 cycles so the final row pulse drains, then pulses
// done.
//
// Ports:
//   clk        : clock, all state changes on the rising edge
//   rstb       : asynchronous active-low reset
//   start      : job request, honoured only in IDLE
//   base_addr  : first line of the job, captured with start
//   seq_len    : number of lines, captured with start (0 = empty job)
//   hold       : stalls read issue; the downstream pipeline keeps moving
//   abort      : cancels the running job (wins over hold and start)
//   rd_en      : input-memory read strobe
//   rd_addr    : read address, wraps modulo 2^ADDR_WIDTH
//   buf_we     : row-buffer write strobe (rd_en delayed one cycle)
//   buf_sel    : row buffer written, valid with buf_we
//   row_valid  : skewed per-row valids into the PE array
//   busy       : high whenever a job is in progress
//   done       : one-cycle job-complete pulse
//   perf_cycles: busy-cycle counter of the last/current job, saturating
//                (only with SA_FEED_SCHED_PERF_EN defined)
//
// Build option: define SA_FEED_SCHED_PERF_EN to add perf_cycles.
// -----------------------------------------------------------------------------
module sa_feed_sched
  import sa_pkg::*;
#(
  parameter int PE_DIM     = SA_PE_DIM_DEFAULT,
  parameter int ADDR_WIDTH = 8,
  parameter int SEQ_W      = 8
) (
  input  logic                              clk,
  input  logic                              rstb,
  input  logic                              start,
  input  logic [ADDR_WIDTH-1:0]             base_addr,
  input  logic [SEQ_W-1:0]                  seq_len,
  input  logic                              hold,
  input  logic                              abort,
  output logic                              rd_en,
  output logic [ADDR_WIDTH-1:0]             rd_addr,
  output logic                              buf_we,
  output logic [sa_sel_width(PE_DIM)-1:0]   buf_sel,
  output logic [PE_DIM-1:0]                 row_valid,
  output logic                              busy,
  output logic                              done
`ifdef SA_FEED_SCHED_PERF_EN
  ,
  output logic [15:0]                       perf_cycles
`endif
);

  localparam int SEL_W   = sa_sel_width(PE_DIM);
  localparam int FLUSH_W = $clog2(PE_DIM + 2);

  localparam logic [SEL_W-1:0]   SEL_LAST   = SEL_W'(PE_DIM - 1);
  localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(PE_DIM);

  sa_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [SEQ_W-1:0]      len_q;
  logic [SEQ_W-1:0]      line_q;
  logic [SEL_W-1:0]      sel_q;        // line_q mod PE_DIM, kept incrementally
  logic [FLUSH_W-1:0]    flush_cnt_q;
  logic                  buf_we_q;
  logic [SEL_W-1:0]      buf_sel_q;

  logic                  job_start;
  logic                  issue_last;
  logic                  pipe_clear;

  assign issue_last = (line_q == (len_q - SEQ_W'(1)));
  // Abort only cancels a running job; in IDLE there is nothing to cancel.
  assign pipe_clear = abort && (state_q != ST_IDLE);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of block ordering.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and control outputs
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_d   = state_q;
    rd_en     = 1'b0;
    done      = 1'b0;
    job_start = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          job_start = 1'b1;
          state_d   = (seq_len == '0) ? ST_DONE : ST_FETCH;
        end
      end

      ST_FETCH: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (!hold) begin
          rd_en = 1'b1;
          if (issue_last) begin
            state_d = ST_FLUSH;
          end
        end
      end

      ST_FLUSH: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (flush_cnt_q == FLUSH_LAST) begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        if (!abort) begin
          done = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Job registers and read address generation
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      base_q <= '0;
      len_q  <= '0;
      line_q <= '0;
      sel_q  <= '0;
    end else if (job_start) begin
      base_q <= base_addr;
      len_q  <= seq_len;
      line_q <= '0;
      sel_q  <= '0;
    end else if (rd_en) begin
      line_q <= line_q + SEQ_W'(1);
      sel_q  <= (sel_q == SEL_LAST) ? '0 : sel_q + SEL_W'(1);
    end
  end

  assign rd_addr = base_q + ADDR_WIDTH'(line_q);

  // Counts the PE_DIM+1 drain cycles; reads zero on the first FLUSH cycle.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      flush_cnt_q <= '0;
    end else if (state_q == ST_FLUSH) begin
      flush_cnt_q <= flush_cnt_q + FLUSH_W'(1);
    end else begin
      flush_cnt_q <= '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Read-return stage: memory data lands one cycle after rd_en.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      buf_we_q  <= 1'b0;
      buf_sel_q <= '0;
    end else if (pipe_clear) begin
      buf_we_q  <= 1'b0;
      buf_sel_q <= '0;
    end else begin
      buf_we_q  <= rd_en;
      buf_sel_q <= sel_q;
    end
  end

  assign buf_we  = buf_we_q;
  assign buf_sel = buf_sel_q;

  sa_skew_pipe #(
    .DEPTH (PE_DIM)
  ) u_skew (
    .clk   (clk),
    .rstb  (rstb),
    .clear (pipe_clear),
    .din   (buf_we_q),
    .dout  (row_valid)
  );

  assign busy = (state_q != ST_IDLE);

`ifdef SA_FEED_SCHED_PERF_EN
  // ---------------------------------------------------------------------------
  // Busy-cycle counter; value stays visible after done until the next start.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      perf_cycles <= '0;
    end else if (job_start) begin
      perf_cycles <= '0;
    end else if (busy && (perf_cycles != 16'hFFFF)) begin
      perf_cycles <= perf_cycles + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sa_feed_sched.sv
// -----------------------------------------------------------------------------
// tb_sa_feed_sched
// Self-checking bench for sa_feed_sched (PE_DIM=3, 8-bit address/length).
// Each job is described as an event timeline (which cycle issues which line,
// when each row sees it, when done fires) and the DUT is compared against it
// every cycle. Inputs change 1 time unit after the rising edge; outputs are
// sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_sa_feed_sched;

  localparam int PE   = 3;
  localparam int AW   = 8;
  localparam int SW   = 8;
  localparam int MAXC = 80;

  logic          clk = 1'b0;
  logic          rstb;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [SW-1:0] seq_len;
  logic          hold;
  logic          abort;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic          buf_we;
  logic [1:0]    buf_sel;
  logic [PE-1:0] row_valid;
  logic          busy;
  logic          done;
`ifdef SA_FEED_SCHED_PERF_EN
  logic [15:0]   perf_cycles;
`endif

  sa_feed_sched #(
    .PE_DIM     (PE),
    .ADDR_WIDTH (AW),
    .SEQ_W      (SW)
  ) dut (
    .clk       (clk),
    .rstb      (rstb),
    .start     (start),
    .base_addr (base_addr),
    .seq_len   (seq_len),
    .hold      (hold),
    .abort     (abort),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .buf_we    (buf_we),
    .buf_sel   (buf_sel),
    .row_valid (row_valid),
    .busy      (busy),
    .done      (done)
`ifdef SA_FEED_SCHED_PERF_EN
    ,
    .perf_cycles (perf_cycles)
`endif
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Stimulus per cycle of a job (cycle 0 = cycle start is sampled).
  logic hold_v  [MAXC];
  logic start_v [MAXC];   // extra start requests while busy

  // Expected per-cycle outputs.
  logic          exp_rd   [MAXC];
  logic [AW-1:0] exp_addr [MAXC];
  logic          exp_we   [MAXC];
  logic [1:0]    exp_sel  [MAXC];
  logic [PE-1:0] exp_rv   [MAXC];
  logic          exp_busy [MAXC];
  logic          exp_done [MAXC];
  int            ncyc;
  int            nbusy;

  task automatic clear_stim();
    for (int c = 0; c < MAXC; c++) begin
      hold_v[c]  = 1'b0;
      start_v[c] = 1'b0;
    end
  endtask

  // Timeline model: lines are issued one per non-held cycle starting at
  // cycle 1; each issued line is written one cycle later and reaches row i
  // 2+i cycles after issue. Drain is PE+1 cycles, then a one-cycle done.
  // An abort in cycle ab wipes everything after ab, plus the read and done
  // of cycle ab itself. ab < 0 means no abort.
  task automatic build_model(input int len, input logic [AW-1:0] base, input int ab);
    int c;
    int line;
    int last;
    int done_c;
    int end_c;
    for (int k = 0; k < MAXC; k++) begin
      exp_rd[k]   = 1'b0;
      exp_addr[k] = '0;
      exp_we[k]   = 1'b0;
      exp_sel[k]  = '0;
      exp_rv[k]   = '0;
      exp_busy[k] = 1'b0;
      exp_done[k] = 1'b0;
    end
    c      = 1;
    line   = 0;
    last   = 0;
    done_c = 1;
    while (line < len && c < MAXC - PE - 8) begin
      if (c == ab) break;
      if (!hold_v[c]) begin
        exp_rd[c]       = 1'b1;
        exp_addr[c]     = base + AW'(line);
        exp_we[c+1]     = 1'b1;
        exp_sel[c+1]    = 2'(line % PE);
        for (int i = 0; i < PE; i++) exp_rv[c+2+i][i] = 1'b1;
        last = c;
        line++;
      end
      c++;
    end
    if (len > 0) done_c = last + PE + 2;
    for (int k = 1; k <= done_c; k++) exp_busy[k] = 1'b1;
    exp_done[done_c] = 1'b1;
    end_c = done_c;
    if (ab >= 0) begin
      for (int k = ab + 1; k < MAXC; k++) begin
        exp_rd[k]   = 1'b0;
        exp_we[k]   = 1'b0;
        exp_rv[k]   = '0;
        exp_busy[k] = 1'b0;
        exp_done[k] = 1'b0;
      end
      exp_rd[ab]   = 1'b0;
      exp_done[ab] = 1'b0;
      if (ab == 0) exp_busy[0] = 1'b0;
      if (ab < end_c) end_c = ab;
      if (ab > end_c) end_c = ab;
    end
    ncyc  = end_c + 4;
    nbusy = 0;
    for (int k = 0; k < MAXC; k++) if (exp_busy[k]) nbusy++;
  endtask

  // Drives one job from cycle 0 and compares every output every cycle.
  // Entry/exit point: 1 time unit after a rising edge, DUT idle.
  task automatic run_job(input string tag, input int len, input logic [AW-1:0] base,
                         input int ab);
    build_model(len, base, ab);
    for (int c = 0; c < ncyc; c++) begin
      start     = (c == 0) ? 1'b1 : (start_v[c] & exp_busy[c]);
      seq_len   = (c == 0) ? SW'(len) : SW'($urandom_range(0, 255));
      base_addr = (c == 0) ? base : AW'($urandom);
      hold      = hold_v[c];
      abort     = (c == ab);
      @(negedge clk);
      vectors++;
      if (rd_en !== exp_rd[c]) begin
        miscompares++;
        $display("FAIL %s c%0d rd_en got %0b want %0b", tag, c, rd_en, exp_rd[c]);
      end
      if (exp_rd[c]) begin
        vectors++;
        if (rd_addr !== exp_addr[c]) begin
          miscompares++;
          $display("FAIL %s c%0d rd_addr got %0h want %0h", tag, c, rd_addr, exp_addr[c]);
        end
      end
      vectors++;
      if (buf_we !== exp_we[c]) begin
        miscompares++;
        $display("FAIL %s c%0d buf_we got %0b want %0b", tag, c, buf_we, exp_we[c]);
      end
      if (exp_we[c]) begin
        vectors++;
        if (buf_sel !== exp_sel[c]) begin
          miscompares++;
          $display("FAIL %s c%0d buf_sel got %0d want %0d", tag, c, buf_sel, exp_sel[c]);
        end
      end
      vectors++;
      if (row_valid !== exp_rv[c]) begin
        miscompares++;
        $display("FAIL %s c%0d row_valid got %b want %b", tag, c, row_valid, exp_rv[c]);
      end
      vectors++;
      if (busy !== exp_busy[c]) begin
        miscompares++;
        $display("FAIL %s c%0d busy got %0b want %0b", tag, c, busy, exp_busy[c]);
      end
      vectors++;
      if (done !== exp_done[c]) begin
        miscompares++;
        $display("FAIL %s c%0d done got %0b want %0b", tag, c, done, exp_done[c]);
      end
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    hold  = 1'b0;
    abort = 1'b0;
`ifdef SA_FEED_SCHED_PERF_EN
    if (ab != 0) begin
      vectors++;
      if (perf_cycles !== 16'(nbusy)) begin
        miscompares++;
        $display("FAIL %s perf_cycles got %0d want %0d", tag, perf_cycles, nbusy);
      end
    end
`endif
  endtask

  task automatic test_reset();
    rstb      = 1'b0;
    start     = 1'b0;
    hold      = 1'b0;
    abort     = 1'b0;
    base_addr = '0;
    seq_len   = '0;
    #12;
    vectors++;
    if ({rd_en, rd_addr, buf_we, buf_sel, row_valid, busy, done} !== '0) begin
      miscompares++;
      $display("FAIL reset outputs got %b want all zero",
               {rd_en, rd_addr, buf_we, buf_sel, row_valid, busy, done});
    end
    #1 rstb = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    clear_stim();
    run_job("basic", 4, 8'h10, -1);
  endtask

  task automatic test_zero_len();
    clear_stim();
    run_job("zero_len", 0, 8'h33, -1);
  endtask

  task automatic test_addr_wrap();
    clear_stim();
    run_job("wrap", 4, 8'hFE, -1);
  endtask

  task automatic test_hold();
    clear_stim();
    hold_v[2] = 1'b1;
    hold_v[3] = 1'b1;
    run_job("hold", 4, 8'h20, -1);
  endtask

  task automatic test_abort();
    clear_stim();
    run_job("abort_fetch", 4, 8'h50, 3);
    clear_stim();
    run_job("after_abort", 4, 8'h60, -1);
    clear_stim();
    run_job("abort_flush", 2, 8'h70, 5);
    clear_stim();
    run_job("abort_done", 0, 8'h80, 1);
    clear_stim();
    run_job("start_abort_idle", 5, 8'h90, 0);
  endtask

  task automatic test_start_while_busy();
    clear_stim();
    for (int c = 1; c < 12; c++) start_v[c] = 1'b1;
    run_job("start_busy", 3, 8'hA0, -1);
  endtask

  task automatic test_random();
    int len;
    int ab;
    for (int j = 0; j < 25; j++) begin
      clear_stim();
      len = $urandom_range(0, 10);
      for (int c = 1; c < 20; c++) begin
        hold_v[c]  = ($urandom_range(0, 9) < 3);
        start_v[c] = ($urandom_range(0, 9) < 2);
      end
      ab = ($urandom_range(0, 2) == 0) ? $urandom_range(0, len + PE + 3) : -1;
      run_job("random", len, AW'($urandom), ab);
    end
  endtask

  task automatic test_reset_mid_flush();
    clear_stim();
    start     = 1'b1;
    seq_len   = 8'd3;
    base_addr = 8'h40;
    @(posedge clk);
    #1;
    start = 1'b0;
    // Now in cycle 1; FLUSH spans cycles 4..7.
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_flush busy-before got %0b want 1", busy);
    end
    #2 rstb = 1'b0;
    #1;
    vectors++;
    if ({rd_en, rd_addr, buf_we, buf_sel, row_valid, busy, done} !== '0) begin
      miscompares++;
      $display("FAIL rst_flush outputs got %b want all zero",
               {rd_en, rd_addr, buf_we, buf_sel, row_valid, busy, done});
    end
    repeat (3) begin
      @(negedge clk);
      vectors++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL rst_flush held done/busy got %0b%0b want 00", done, busy);
      end
    end
    #2 rstb = 1'b1;
    @(posedge clk);
    #1;
    clear_stim();
    run_job("after_reset", 2, 8'hC0, -1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_addr_wrap();
    test_hold();
    test_abort();
    test_start_while_busy();
    test_reset_mid_flush();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Absolute time bound so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sa_feed_sched.md
SA_FEED_SCHED -- requirements
Module: sa_feed_sched

Interface
REQ-001 Parameter PE_DIM, default 3: systolic array dimension; number of feeder row buffers and skew stages.
REQ-002 Parameter ADDR_WIDTH, default 8: input-memory line address width.
REQ-003 Parameter SEQ_W, default 8: width of the job line count.
REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 rstb  input  1  reset; asynchronous, active-low.
REQ-006 start  input  1  job request; sampled only in IDLE.
REQ-007 base_addr  input  ADDR_WIDTH  first memory line of the job; captured with start.
REQ-008 seq_len  input  SEQ_W  number of lines to stream; captured with start.
REQ-009 hold  input  1  suppresses new read issue while high.
REQ-010 abort  input  1  cancels the current job.
REQ-011 rd_en  output  1  input-memory read strobe; 1-cycle read latency.
REQ-012 rd_addr  output  ADDR_WIDTH  read address, valid with rd_en.
REQ-013 buf_we  output  1  write strobe into the row buffer selected by buf_sel, asserted one cycle after rd_en.
REQ-014 buf_sel  output  $clog2(PE_DIM)  target row buffer, valid with buf_we.
REQ-015 row_valid  output  PE_DIM  skewed per-row valid to the PE array.
REQ-016 busy  output  1  high whenever the state is not IDLE.
REQ-017 done  output  1  single-cycle job-complete pulse.

Function
REQ-018 States: IDLE, FETCH, FLUSH, DONE.
REQ-019 IDLE->FETCH on start with seq_len>0; IDLE->DONE on start with seq_len==0; start in any other state is ignored.
REQ-020 FETCH: each cycle with hold low, rd_en=1, rd_addr=base_addr+line, line increments; rd_addr wraps modulo 2^ADDR_WIDTH.
REQ-021 FETCH with hold high: rd_en=0, line and address frozen; downstream pipeline keeps advancing.
REQ-022 FETCH->FLUSH on the cycle that issues line seq_len-1.
REQ-023 buf_sel for line k is k mod PE_DIM; it restarts at 0 for every job.
REQ-024 buf_we and buf_sel are rd_en and line mod PE_DIM delayed by exactly one cycle.
REQ-025 row_valid[0] is buf_we delayed one cycle; row_valid[i] is row_valid[0] delayed i cycles.
REQ-026 FLUSH lasts exactly PE_DIM+1 cycles, then moves to DONE, so the last row_valid[PE_DIM-1] pulse occurs in the final FLUSH cycle.
REQ-027 DONE lasts one cycle with done=1, then moves to IDLE.
REQ-028 With hold never asserted, start sampled at cycle 0 gives rd_en in cycles 1..L, FLUSH in cycles L+1..L+PE_DIM+1, and done in cycle L+PE_DIM+2, where L=seq_len.
REQ-029 abort in FETCH, FLUSH or DONE: IDLE next cycle; rd_en, buf_we and row_valid pipelines cleared; done not asserted. abort has priority over hold and over the state transition of the same cycle.
REQ-030 abort in IDLE has no effect; simultaneous start and abort in IDLE: abort wins and the job is not started.

Reset
REQ-031 rstb low: state IDLE; all outputs 0; line counter, captured base_addr/seq_len and all delay stages 0.
REQ-032 Reset mid-job discards the job without a done pulse; operation resumes on the first clk edge after rstb deasserts.

Configuration
REQ-033 SA_FEED_SCHED_PERF_EN defined: adds output perf_cycles[15:0], cleared on job start, incremented each busy cycle, saturating at 16'hFFFF, held after done until the next start, reset to 0.
REQ-034 SA_FEED_SCHED_PERF_EN undefined: no perf_cycles port and no associated logic.

Structure
REQ-035 Package sa_pkg holds the state enum type and the default PE_DIM constant shared with the feeder and PE array.
REQ-036 Sub-module sa_skew_pipe: a parameterised, abort-clearable 1-bit delay line producing row_valid.

Verification
REQ-037 PE_DIM=3, base=0x10, seq_len=4, no hold -> rd_addr 0x10..0x13 in cycles 1-4; buf_sel 0,1,2,0 in cycles 2-5; row_valid[2] high in cycles 5-8; done in cycle 9.
REQ-038 seq_len=0 -> no rd_en; done in cycle 1; busy high in cycle 1 only.
REQ-039 base=0xFE, seq_len=4 -> rd_addr 0xFE,0xFF,0x00,0x01.
REQ-040 seq_len=4, hold high in cycles 2-3 -> rd_en in cycles 1,4,5,6; done in cycle 11; row_valid[0] gap in cycles 4-5.
REQ-041 Abort in cycle 3 of a seq_len=4 job -> IDLE in cycle 4; all row_valid 0 from cycle 4; no done pulse; new start then accepted normally.
REQ-042 start asserted while busy -> ignored; rstb pulsed mid-FLUSH -> all outputs 0 immediately, no done pulse.
